acq_vp_arbiter: RTL and testbench

Shares the single acquisition RAM/SRAM viewport between the VME host path and the internal acquisition writer. Each side issues single-cycle strobes; the arbiter latches them, grants the RAM to one requester at a time (round-robin), drives the viewport strobe, and returns the RAM done pulse plus read data to the owner. It sits between the register-bank viewport port and the acquisition memory controller.

---
 rtl/acq_vp_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_acq_vp_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_vp_arbiter.sv
// acq_vp_arbiter: round-robin owner of the acquisition RAM viewport, shared by the
// VME host path and the acquisition writer. Single-cycle strobes are latched into
// one pending slot per side, one access is granted at a time, and the RAM done
// pulse (plus read data) is routed back to the owner.
// Optional: define ACQ_VP_TIMEOUT_EN to force completion after TIMEOUT cycles
// without a RAM done (reported through to_err).
module acq_vp_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   input  logic              h_rd,
   input  logic              h_wr,
   output logic [DATA_W-1:0] h_rdata,
   output logic              h_rd_done,
   output logic              h_wr_done,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              a_wr,
   output logic              a_done,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_rd,
   output logic              m_wr,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rd_done,
   input  logic              m_wr_done,
   output logic              busy,
   output logic              to_err
);

   // The timeout counter is 8 bits wide.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
      $error("acq_vp_arbiter: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {StIdle, StHost, StAcq} state_e;

   state_e              state_q, state_d;
   logic                h_v_q, h_v_d;
   logic                h_kwr_q, h_kwr_d;      // host slot kind: 1 = write, 0 = read
   logic [ADDR_W-1:0]   h_addr_q, h_addr_d;
   logic [DATA_W-1:0]   h_wdata_q, h_wdata_d;
   logic                a_v_q, a_v_d;
   logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
   logic [DATA_W-1:0]   a_wdata_q, a_wdata_d;
   logic                last_acq_q, last_acq_d; // 1 = acquisition side served last
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic                m_rd_q, m_rd_d;
   logic                m_wr_q, m_wr_d;
   logic [DATA_W-1:0]   h_rdata_q, h_rdata_d;
   logic                h_rd_done_q, h_rd_done_d;
   logic                h_wr_done_q, h_wr_done_d;
   logic                a_done_q, a_done_d;
   logic                to_err_q, to_err_d;
   logic                grant_host, grant_acq;
   logic                done_ok, expired;

`ifdef ACQ_VP_TIMEOUT_EN
   localparam logic [7:0] CntInit = 8'(TIMEOUT);
   logic [7:0]          cnt_q, cnt_d;

   // Timeout counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

   // State, slot and output registers; reset abandons any outstanding access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         h_v_q       <= 1'b0;
         h_kwr_q     <= 1'b0;
         h_addr_q    <= '0;
         h_wdata_q   <= '0;
         a_v_q       <= 1'b0;
         a_addr_q    <= '0;
         a_wdata_q   <= '0;
         last_acq_q  <= 1'b1;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         m_rd_q      <= 1'b0;
         m_wr_q      <= 1'b0;
         h_rdata_q   <= '0;
         h_rd_done_q <= 1'b0;
         h_wr_done_q <= 1'b0;
         a_done_q    <= 1'b0;
         to_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_v_q       <= h_v_d;
         h_kwr_q     <= h_kwr_d;
         h_addr_q    <= h_addr_d;
         h_wdata_q   <= h_wdata_d;
         a_v_q       <= a_v_d;
         a_addr_q    <= a_addr_d;
         a_wdata_q   <= a_wdata_d;
         last_acq_q  <= last_acq_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_rd_q      <= m_rd_d;
         m_wr_q      <= m_wr_d;
         h_rdata_q   <= h_rdata_d;
         h_rd_done_q <= h_rd_done_d;
         h_wr_done_q <= h_wr_done_d;
         a_done_q    <= a_done_d;
         to_err_q    <= to_err_d;
      end
   end

   // Slot capture, arbitration and completion. Grants look at the next-state slot
   // view so a strobe in an idle cycle reaches the viewport one cycle later.
   always_comb begin
      state_d     = state_q;
      h_v_d       = h_v_q;
      h_kwr_d     = h_kwr_q;
      h_addr_d    = h_addr_q;
      h_wdata_d   = h_wdata_q;
      a_v_d       = a_v_q;
      a_addr_d    = a_addr_q;
      a_wdata_d   = a_wdata_q;
      last_acq_d  = last_acq_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_rd_d      = 1'b0;
      m_wr_d      = 1'b0;
      h_rdata_d   = h_rdata_q;
      h_rd_done_d = 1'b0;
      h_wr_done_d = 1'b0;
      a_done_d    = 1'b0;
      to_err_d    = 1'b0;
      grant_host  = 1'b0;
      grant_acq   = 1'b0;
      done_ok     = 1'b0;
      expired     = 1'b0;
`ifdef ACQ_VP_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      // Strobes only land in an empty slot; a write wins over a same-cycle read.
      if (!h_v_q && (h_rd || h_wr)) begin
         h_v_d     = 1'b1;
         h_kwr_d   = h_wr;
         h_addr_d  = h_addr;
         h_wdata_d = h_wdata;
      end
      if (!a_v_q && a_wr) begin
         a_v_d     = 1'b1;
         a_addr_d  = a_addr;
         a_wdata_d = a_wdata;
      end

      unique case (state_q)
         StIdle: begin
            grant_host = h_v_d && (!a_v_d || last_acq_q);
            grant_acq  = a_v_d && !grant_host;
            if (grant_host) begin
               state_d   = StHost;
               m_addr_d  = h_addr_d;
               m_wdata_d = h_wdata_d;
               m_wr_d    = h_kwr_d;
               m_rd_d    = !h_kwr_d;
            end else if (grant_acq) begin
               state_d   = StAcq;
               m_addr_d  = a_addr_d;
               m_wdata_d = a_wdata_d;
               m_wr_d    = 1'b1;
            end
`ifdef ACQ_VP_TIMEOUT_EN
            cnt_d = CntInit;
`endif
         end
         StHost: begin
            done_ok = h_kwr_q ? m_wr_done : m_rd_done;
`ifdef ACQ_VP_TIMEOUT_EN
            expired = !done_ok && (cnt_q == 8'd0);
`endif
            if (done_ok || expired) begin
               state_d     = StIdle;
               h_v_d       = 1'b0;
               last_acq_d  = 1'b0;
               h_wr_done_d = h_kwr_q;
               h_rd_done_d = !h_kwr_q;
               to_err_d    = expired;
               if (!h_kwr_q) h_rdata_d = done_ok ? m_rdata : '0;
            end
         end
         StAcq: begin
            done_ok = m_wr_done;
`ifdef ACQ_VP_TIMEOUT_EN
            expired = !done_ok && (cnt_q == 8'd0);
`endif
            if (done_ok || expired) begin
               state_d    = StIdle;
               a_v_d      = 1'b0;
               last_acq_d = 1'b1;
               a_done_d   = 1'b1;
               to_err_d   = expired;
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef ACQ_VP_TIMEOUT_EN
      if (state_q != StIdle && !done_ok && !expired) cnt_d = cnt_q - 8'd1;
`endif
   end

   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign m_rd      = m_rd_q;
   assign m_wr      = m_wr_q;
   assign h_rdata   = h_rdata_q;
   assign h_rd_done = h_rd_done_q;
   assign h_wr_done = h_wr_done_q;
   assign a_done    = a_done_q;
   assign busy      = (state_q != StIdle);
   assign to_err    = to_err_q;

endmodule

// File: tb/tb_acq_vp_arbiter.sv
// Self-checking bench for acq_vp_arbiter: scoreboard of expected viewport accesses
// and completions, a behavioural RAM with programmable latency, and directed
// cycle-accurate checks for arbitration, drop, reset and (optionally) timeout.
module tb_acq_vp_arbiter;

   typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] wdata;} mexp_t;
   typedef struct packed {logic [1:0] who; logic [15:0] rdata;} dexp_t;
   localparam logic [1:0] WhoHrd = 2'd0, WhoHwr = 2'd1, WhoAcq = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] h_addr, h_wdata, h_rdata, a_addr, a_wdata;
   logic        h_rd, h_wr, h_rd_done, h_wr_done, a_wr, a_done;
   logic [15:0] m_addr, m_wdata, m_rdata;
   logic        m_rd, m_wr, m_rd_done, m_wr_done, busy, to_err;

   mexp_t       exp_m[$];
   dexp_t       exp_d[$];
   int          n_cmp = 0, n_err = 0, cyc = 0;
   int          m_cyc_q[$];
   int          d_cyc_q[$];
   int          to_err_cnt = 0, to_err_cyc = -1, a_done_cnt = 0;
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] ram [logic [15:0]];
   int          ram_lat = 2;
   bit          ram_mute = 1'b0;
   int          inj_cnt = 0, inj_seen = 0;
   bit          inj_wr = 1'b0;
   bit          r_wr;
   logic [15:0] r_addr, r_data;

   acq_vp_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_rd(h_rd), .h_wr(h_wr),
      .h_rdata(h_rdata), .h_rd_done(h_rd_done), .h_wr_done(h_wr_done),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_wr(a_wr), .a_done(a_done),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
      .m_rdata(m_rdata), .m_rd_done(m_rd_done), .m_wr_done(m_wr_done),
      .busy(busy), .to_err(to_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural RAM: answers each viewport strobe after ram_lat cycles, or injects
   // a stray done pulse on request.
   initial begin
      m_rdata = '0; m_rd_done = 1'b0; m_wr_done = 1'b0;
      ram[16'h0012] = 16'hBEEF;
      forever begin
         @(negedge clk);
         if (inj_cnt != inj_seen) begin
            inj_seen = inj_cnt;
            @(posedge clk); #1;
            m_rdata = 16'hDEAD; m_wr_done = inj_wr; m_rd_done = !inj_wr;
            @(posedge clk); #1;
            m_wr_done = 1'b0; m_rd_done = 1'b0;
         end else if (rst_n && !ram_mute && (m_rd || m_wr)) begin
            r_wr = m_wr; r_addr = m_addr; r_data = m_wdata;
            repeat (ram_lat - 1) @(posedge clk);
            @(posedge clk); #1;
            if (r_wr) begin
               ram[r_addr] = r_data;
               m_wr_done = 1'b1;
            end else begin
               m_rdata = ram.exists(r_addr) ? ram[r_addr] : 16'h0000;
               m_rd_done = 1'b1;
            end
            @(posedge clk); #1;
            m_wr_done = 1'b0; m_rd_done = 1'b0;
         end
      end
   end

   task automatic got_done(input logic [1:0] who);
      dexp_t e;
      d_cyc_q.push_back(cyc);
      check_eq("done_expected", exp_d.size() != 0, 1);
      if (exp_d.size() != 0) begin
         e = exp_d.pop_front();
         check_eq("done_owner", who, e.who);
         if (who == WhoHrd) check_eq("h_rdata", h_rdata, e.rdata);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   initial forever begin
      mexp_t e;
      @(negedge clk);
      if (m_rd || m_wr) begin
         m_cyc_q.push_back(cyc);
         check_eq("m_rd_wr_excl", m_rd & m_wr, 0);
         check_eq("m_access_expected", exp_m.size() != 0, 1);
         if (exp_m.size() != 0) begin
            e = exp_m.pop_front();
            check_eq("m_kind", m_wr, e.wr);
            check_eq("m_addr", m_addr, e.addr);
            if (e.wr) check_eq("m_wdata", m_wdata, e.wdata);
         end
      end
      if (h_rd_done || h_wr_done) check_eq("h_done_excl", h_rd_done & h_wr_done, 0);
      if (h_rd_done) got_done(WhoHrd);
      if (h_wr_done) got_done(WhoHwr);
      if (a_done) begin
         a_done_cnt++;
         got_done(WhoAcq);
      end
      if (to_err) begin
         to_err_cnt++;
         to_err_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy && exp_m.size() == 0 && exp_d.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq({tag, "_drain"}, ok, 1);
      step(); step();
   endtask

   task automatic push_m(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
      exp_m.push_back('{wr: wr, addr: addr, wdata: wdata});
   endtask

   task automatic push_d(input logic [1:0] who, input logic [15:0] rdata);
      exp_d.push_back('{who: who, rdata: rdata});
   endtask

   task automatic host_rd(input logic [15:0] addr);
      push_m(1'b0, addr, 16'h0);
      push_d(WhoHrd, ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000);
      h_rd = 1'b1; h_addr = addr;
      step();
      h_rd = 1'b0;
   endtask

   task automatic host_wr(input logic [15:0] addr, input logic [15:0] data);
      ref_mem[addr] = data;
      push_m(1'b1, addr, data);
      push_d(WhoHwr, 16'h0);
      h_wr = 1'b1; h_addr = addr; h_wdata = data;
      step();
      h_wr = 1'b0;
   endtask

   task automatic acq_wr(input logic [15:0] addr, input logic [15:0] data);
      ref_mem[addr] = data;
      push_m(1'b1, addr, data);
      push_d(WhoAcq, 16'h0);
      a_wr = 1'b1; a_addr = addr; a_wdata = data;
      step();
      a_wr = 1'b0;
   endtask

   initial begin
      int c0, base;
      rst_n = 1'b0; h_rd = 1'b0; h_wr = 1'b0; a_wr = 1'b0;
      h_addr = '0; h_wdata = '0; a_addr = '0; a_wdata = '0;
      ref_mem[16'h0012] = 16'hBEEF;
      repeat (3) step();
      @(negedge clk);
      check_eq("reset_strobes", {m_rd, m_wr, busy, to_err}, 0);
      check_eq("reset_dones", {h_rd_done, h_wr_done, a_done}, 0);
      check_eq("reset_m_bus", {m_addr, m_wdata}, 0);
      check_eq("reset_h_rdata", h_rdata, 0);
      step();
      rst_n = 1'b1;
      step();

      // Host read, RAM answers 3 cycles after m_rd.
      ram_lat = 3;
      c0 = cyc;
      host_rd(16'h0012);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check_eq($sformatf("t1_busy_c%0d", i), busy, (i <= 4) ? 1 : 0);
         check_eq($sformatf("t1_m_rd_c%0d", i), m_rd, (i == 1) ? 1 : 0);
         check_eq($sformatf("t1_rd_done_c%0d", i), h_rd_done, (i == 5) ? 1 : 0);
      end
      wait_idle("t1");

      // Tie straight after reset: host first, acq granted at done + 2.
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      ram_lat = 2;
      m_cyc_q.delete();
      c0 = cyc;
      ref_mem[16'h0200] = 16'h1111; ref_mem[16'h0300] = 16'h2222;
      push_m(1'b1, 16'h0200, 16'h1111); push_m(1'b1, 16'h0300, 16'h2222);
      push_d(WhoHwr, 16'h0); push_d(WhoAcq, 16'h0);
      h_wr = 1'b1; h_addr = 16'h0200; h_wdata = 16'h1111;
      a_wr = 1'b1; a_addr = 16'h0300; a_wdata = 16'h2222;
      step();
      h_wr = 1'b0; a_wr = 1'b0;
      wait_idle("tie1");
      check_eq("tie1_grants", m_cyc_q.size(), 2);
      check_eq("tie1_host_cyc", (m_cyc_q.size() > 0) ? m_cyc_q[0] : -1, c0 + 1);
      check_eq("tie1_acq_cyc", (m_cyc_q.size() > 1) ? m_cyc_q[1] : -1, c0 + 5);

      // After a host-only access, a tie goes to the acquisition side.
      host_wr(16'h0210, 16'h3333);
      wait_idle("host_only");
      ref_mem[16'h0310] = 16'h4444; ref_mem[16'h0220] = 16'h5555;
      push_m(1'b1, 16'h0310, 16'h4444); push_m(1'b1, 16'h0220, 16'h5555);
      push_d(WhoAcq, 16'h0); push_d(WhoHwr, 16'h0);
      h_wr = 1'b1; h_addr = 16'h0220; h_wdata = 16'h5555;
      a_wr = 1'b1; a_addr = 16'h0310; a_wdata = 16'h4444;
      step();
      h_wr = 1'b0; a_wr = 1'b0;
      wait_idle("tie2");

      // Strobe while in service is dropped; strobe in the done-pulse cycle is kept.
      ram_lat = 3;
      m_cyc_q.delete();
      base = a_done_cnt;
      c0 = cyc;
      acq_wr(16'h0400, 16'h6666);
      step();
      a_wr = 1'b1; a_addr = 16'h0401; a_wdata = 16'h7777;
      step();
      a_wr = 1'b0;
      step(); step();
      acq_wr(16'h0402, 16'h8888);
      wait_idle("drop");
      check_eq("drop_a_done_cnt", a_done_cnt - base, 2);
      check_eq("drop_grants", m_cyc_q.size(), 2);
      check_eq("accept_on_clear_cyc", (m_cyc_q.size() > 1) ? m_cyc_q[1] : -1, c0 + 6);

      // Read and write strobes together act as a write.
      ram_lat = 2;
      ref_mem[16'h0100] = 16'h1234;
      push_m(1'b1, 16'h0100, 16'h1234);
      push_d(WhoHwr, 16'h0);
      h_rd = 1'b1; h_wr = 1'b1; h_addr = 16'h0100; h_wdata = 16'h1234;
      step();
      h_rd = 1'b0; h_wr = 1'b0;
      wait_idle("rdwr");
      host_rd(16'h0100);
      wait_idle("rdwr_readback");

      // Mixed serial traffic with varying RAM latency.
      for (int i = 0; i < 10; i++) begin
         int unsigned k = $urandom_range(2, 0);
         logic [15:0] ad = 16'h0800 + 16'($urandom_range(7, 0));
         logic [15:0] wd = 16'($urandom);
         ram_lat = int'($urandom_range(4, 1));
         if (k == 0) host_rd(ad);
         else if (k == 1) host_wr(ad, wd);
         else acq_wr(ad, wd);
         wait_idle($sformatf("mix%0d", i));
      end

      // One-cycle reset during an outstanding acquisition write.
      ram_mute = 1'b1;
      base = a_done_cnt;
      push_m(1'b1, 16'h0500, 16'h9999);
      a_wr = 1'b1; a_addr = 16'h0500; a_wdata = 16'h9999;
      step();
      a_wr = 1'b0;
      step(); step();
      rst_n = 1'b0;
      step();
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_m_bus", {m_addr, m_wdata, m_rd, m_wr}, 0);
      check_eq("rst_mid_h_rdata", h_rdata, 0);
      rst_n = 1'b1;
      inj_wr = 1'b1; inj_cnt++;
      repeat (4) step();
      check_eq("rst_mid_no_a_done", a_done_cnt - base, 0);
      check_eq("rst_mid_late_done_busy", busy, 0);
      ram_mute = 1'b0;
      host_rd(16'h0012);
      wait_idle("post_reset_rd");

`ifdef ACQ_VP_TIMEOUT_EN
      // RAM never answers: forced completion 11 cycles after the grant.
      ram_mute = 1'b1;
      d_cyc_q.delete();
      c0 = cyc;
      push_m(1'b0, 16'h0042, 16'h0);
      push_d(WhoHrd, 16'h0000);
      h_rd = 1'b1; h_addr = 16'h0042;
      step();
      h_rd = 1'b0;
      wait_idle("timeout");
      check_eq("timeout_done_cyc", (d_cyc_q.size() > 0) ? d_cyc_q[0] : -1, c0 + 12);
      check_eq("timeout_to_err_cyc", to_err_cyc, c0 + 12);
      inj_wr = 1'b0; inj_cnt++;
      repeat (4) step();
      check_eq("timeout_late_busy", busy, 0);
      check_eq("to_err_count", to_err_cnt, 1);
`else
      check_eq("to_err_count", to_err_cnt, 0);
`endif

      check_eq("exp_m_left", exp_m.size(), 0);
      check_eq("exp_d_left", exp_d.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
